// File: rtl/pipe_ctrl.sv
// Pipeline control for the five-stage core: per-stage stall vector, one-cycle
// flush/redirect on exception or eret, EX-stall watchdog and stall-cycle counter.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
  parameter logic [31:0] ERET_CODE     = 32'h0000_000e,
  parameter int unsigned STALL_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        timeout,
  output logic [31:0] stall_cycles
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(STALL_TIMEOUT);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t      state_q, state_d;
  logic        flush_q, flush_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic        timeout_q, timeout_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [7:0]  ex_cnt_q, ex_cnt_d;
  logic        exc_present;

  assign exc_present = (excepttype_i != 32'h0);

  always_comb begin
    state_d        = state_q;
    flush_d        = 1'b0;
    new_pc_d       = new_pc_q;
    timeout_d      = 1'b0;
    ex_cnt_d       = 8'h0;
    stall          = 6'b000000;
    stall_cycles_d = stall_cycles_q;

    case (state_q)
      RUN: begin
        if (exc_present) begin
          state_d  = FLUSH;
          flush_d  = 1'b1;
          new_pc_d = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
        end else if (stallreq_ex) begin
          stall = 6'b001111;
        end else if (stallreq_id) begin
          stall = 6'b000111;
        end
      end
      FLUSH: begin
        // The flushed MEM stage cannot hold a real exception, so ignore it here.
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    if (rst) begin
      stall = 6'b000000;
    end

    // Watchdog saturates at the limit so a long stall pulses timeout only once.
    if (stall[3]) begin
      if (ex_cnt_q == TIMEOUT_CNT) begin
        ex_cnt_d = ex_cnt_q;
      end else begin
        ex_cnt_d  = ex_cnt_q + 8'd1;
        timeout_d = (ex_cnt_d == TIMEOUT_CNT);
      end
    end

    if (stall != 6'b000000) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      flush_q        <= 1'b0;
      new_pc_q       <= 32'h0;
      timeout_q      <= 1'b0;
      stall_cycles_q <= 32'h0;
      ex_cnt_q       <= 8'h0;
    end else begin
      state_q        <= state_d;
      flush_q        <= flush_d;
      new_pc_q       <= new_pc_d;
      timeout_q      <= timeout_d;
      stall_cycles_q <= stall_cycles_d;
      ex_cnt_q       <= ex_cnt_d;
    end
  end

  assign flush        = flush_q;
  assign new_pc       = new_pc_q;
  assign timeout      = timeout_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a cycle-level behavioural model checked on
// every falling edge, plus literal expectations at the interesting cycles.
module tb_pipe_ctrl;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        timeout;
  logic [31:0] stall_cycles;

  pipe_ctrl #(
    .EXC_VECTOR   (32'h0000_0020),
    .ERET_CODE    (32'h0000_000e),
    .STALL_TIMEOUT(T)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stallreq_id (stallreq_id),
    .stallreq_ex (stallreq_ex),
    .excepttype_i(excepttype_i),
    .cp0_epc_i   (cp0_epc_i),
    .stall       (stall),
    .flush       (flush),
    .new_pc      (new_pc),
    .timeout     (timeout),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what each output must be in the current cycle.
  logic        m_flush = 1'b0;   // previous cycle accepted an exception
  logic [31:0] m_pc = 32'h0;
  logic        m_to = 1'b0;
  int          m_run = 0;        // consecutive EX-freeze cycles, unbounded
  logic [31:0] m_cycles = 32'h0;

  always @(negedge clk) begin
    logic       exc;
    logic [5:0] exp_stall;
    if (rst) begin
      chk("model_stall_rst", {26'h0, stall}, 32'h0);
      m_flush  = 1'b0;
      m_pc     = 32'h0;
      m_to     = 1'b0;
      m_run    = 0;
      m_cycles = 32'h0;
    end else begin
      exc = (excepttype_i != 0) && !m_flush;
      if (m_flush || exc)   exp_stall = 6'b000000;
      else if (stallreq_ex) exp_stall = 6'b001111;
      else if (stallreq_id) exp_stall = 6'b000111;
      else                  exp_stall = 6'b000000;
      chk("model_stall", {26'h0, stall}, {26'h0, exp_stall});
      chk("model_flush", {31'h0, flush}, {31'h0, m_flush});
      chk("model_new_pc", new_pc, m_pc);
      chk("model_timeout", {31'h0, timeout}, {31'h0, m_to});
      chk("model_stall_cycles", stall_cycles, m_cycles);
      m_to  = exp_stall[3] && (m_run + 1 == T);
      m_run = exp_stall[3] ? m_run + 1 : 0;
      if (exp_stall != 0) m_cycles = m_cycles + 1;
      if (exc) m_pc = (excepttype_i == 32'h0e) ? cp0_epc_i : 32'h20;
      m_flush = exc;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stallreq_id = 1'b1; stallreq_ex = 1'b0;
    excepttype_i = 32'h1; cp0_epc_i = 32'h0;
    @(negedge clk); chk("rst_stall0", {26'h0, stall}, 32'h0);
    next_cycle();
    @(negedge clk); chk("rst_stall1", {26'h0, stall}, 32'h0);
    next_cycle();

    rst = 1'b0; stallreq_id = 1'b0; excepttype_i = 32'h0;
    @(negedge clk);
    chk("post_rst_flush", {31'h0, flush}, 32'h0);
    chk("post_rst_new_pc", new_pc, 32'h0);
    chk("post_rst_cycles", stall_cycles, 32'h0);
    next_cycle();

    // Load-use, then both requests together
    stallreq_id = 1'b1;
    @(negedge clk); chk("loaduse_stall", {26'h0, stall}, 32'h07);
    next_cycle();
    stallreq_id = 1'b0;
    @(negedge clk);
    chk("loaduse_release", {26'h0, stall}, 32'h0);
    chk("loaduse_cycles", stall_cycles, 32'h1);
    next_cycle();
    stallreq_id = 1'b1; stallreq_ex = 1'b1;
    @(negedge clk); chk("both_stall", {26'h0, stall}, 32'h0f);
    next_cycle();
    stallreq_id = 1'b0; stallreq_ex = 1'b0;
    next_cycle();

    // Divider stall: 6 cycles, pulse in the 5th cycle (index 4)
    stallreq_ex = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("div_stall", {26'h0, stall}, 32'h0f);
      chk("div_timeout", {31'h0, timeout}, (i == 4) ? 32'h1 : 32'h0);
      next_cycle();
    end
    stallreq_ex = 1'b0;
    @(negedge clk);
    chk("div_no_repulse", {31'h0, timeout}, 32'h0);
    chk("div_cycles", stall_cycles, 32'd8);
    next_cycle();
    stallreq_ex = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("div2_timeout_low", {31'h0, timeout}, 32'h0);
      next_cycle();
    end
    stallreq_ex = 1'b0;
    @(negedge clk); chk("div2_pulse", {31'h0, timeout}, 32'h1);
    next_cycle();

    // Exception beats a pending EX stall
    excepttype_i = 32'h1; stallreq_ex = 1'b1;
    @(negedge clk); chk("exc_stall0", {26'h0, stall}, 32'h0);
    next_cycle();
    excepttype_i = 32'h0;
    @(negedge clk);
    chk("exc_flush", {31'h0, flush}, 32'h1);
    chk("exc_new_pc", new_pc, 32'h20);
    chk("exc_flush_stall", {26'h0, stall}, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("exc_after_flush", {31'h0, flush}, 32'h0);
    chk("exc_after_stall", {26'h0, stall}, 32'h0f);
    next_cycle();
    stallreq_ex = 1'b0;
    next_cycle();

    // eret held three cycles: flush 1,0,1
    cp0_epc_i = 32'h0000_1234; excepttype_i = 32'h0000_000e;
    next_cycle();
    @(negedge clk);
    chk("eret_flush1", {31'h0, flush}, 32'h1);
    chk("eret_pc1", new_pc, 32'h1234);
    next_cycle();
    @(negedge clk); chk("eret_flush2", {31'h0, flush}, 32'h0);
    next_cycle();
    excepttype_i = 32'h0;
    @(negedge clk);
    chk("eret_flush3", {31'h0, flush}, 32'h1);
    chk("eret_pc3", new_pc, 32'h1234);
    next_cycle();

    // Reset in the middle of a flush
    excepttype_i = 32'h1;
    next_cycle();
    excepttype_i = 32'h0; rst = 1'b1;
    @(negedge clk); chk("midflush_flush", {31'h0, flush}, 32'h1);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("midflush_cleared", {31'h0, flush}, 32'h0);
    chk("midflush_pc", new_pc, 32'h0);
    next_cycle();

    // Stall counter wrap
    dut.stall_cycles_q = 32'hFFFF_FFFF;
    m_cycles = 32'hFFFF_FFFF;
    stallreq_id = 1'b1;
    @(negedge clk); chk("wrap_before", stall_cycles, 32'hFFFF_FFFF);
    next_cycle();
    stallreq_id = 1'b0;
    @(negedge clk); chk("wrap_after", stall_cycles, 32'h0);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
